// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for the 32x8 data memory.
// Requester 0 is the core load/store unit, requester 1 the debug/DMA loader.
// Each granted access runs IDLE -> ACCESS -> DONE; ack and read data are
// registered back to the winner. Ties are broken round-robin.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req/we/addr/wdata 0,1       requester command, held stable until ack
//   lock0, lock1                (DMEM_ARB_LOCK_EN only) hold grant for owner
//   ack0, ack1                  one-cycle completion pulse
//   rdata0, rdata1              read result, held until that requester's next ack
//   mem_we, mem_read_addr,
//   mem_write_addr,
//   mem_write_data              memory port (write on posedge clk)
//   mem_read_data               combinational memory read data
//
// Build option: define DMEM_ARB_LOCK_EN to add lock0/lock1 for atomic
// read-modify-write sequences; without it the arbiter is pure round-robin.
//
// state  | meaning
// IDLE   | sample requests, grant and latch command
// ACCESS | drive memory port, capture read data, raise ack
// DONE   | ack visible to winner, update round-robin pointer
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state;
    logic              win;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              last_grant;

    logic              elig0;
    logic              elig1;
    logic              grant_any;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_LOCK_EN
    logic              lock_active;
    logic              lock_owner;
    logic              sel_lock;
`endif

    always_comb begin
        elig0 = req0;
        elig1 = req1;
`ifdef DMEM_ARB_LOCK_EN
        // While locked, only the owner may be granted; the other waits.
        if (lock_active) begin
            if (lock_owner) begin
                elig0 = 1'b0;
            end else begin
                elig1 = 1'b0;
            end
        end
`endif
        grant_any = elig0 | elig1;
        if (elig0 && elig1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = elig1;
        end
    end

    assign sel_we    = grant_id ? we1    : we0;
    assign sel_addr  = grant_id ? addr1  : addr0;
    assign sel_wdata = grant_id ? wdata1 : wdata0;
`ifdef DMEM_ARB_LOCK_EN
    assign sel_lock  = grant_id ? lock1  : lock0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            win        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        win       <= grant_id;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        state     <= ACCESS;
`ifdef DMEM_ARB_LOCK_EN
                        // An owner grant with lock low releases the lock; the
                        // other requester cannot be served before it completes.
                        lock_active <= sel_lock;
                        lock_owner  <= grant_id;
`endif
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (win) begin
                            rdata1 <= mem_read_data;
                        end else begin
                            rdata0 <= mem_read_data;
                        end
                    end
                    ack0  <= ~win;
                    ack1  <= win;
                    state <= DONE;
                end
                DONE: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    last_grant <= win;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // rst_n gates the strobe so a reset landing in ACCESS never writes memory.
    assign mem_we         = (state == ACCESS) & lat_we & rst_n;
    assign mem_read_addr  = lat_addr;
    assign mem_write_addr = lat_addr;
    assign mem_write_data = lat_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, mem_we;
    logic [7:0] rdata0, rdata1, mem_write_data, mem_read_data;
    logic [4:0] mem_read_addr, mem_write_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_read_addr(mem_read_addr),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Memory attached to the DUT; initial contents are 8'h10 + address.
    logic [7:0] env_mem [32];
    bit         env_init;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= 8'(8'h10 + i);
            env_init <= 1'b1;
        end else if (mem_we) begin
            env_mem[mem_write_addr] <= mem_write_data;
        end
    end
    assign mem_read_data = env_mem[mem_read_addr];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int ack0_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an access granted at edge g drives the memory during
    // the cycle after g, commits at edge g+1 (ack visible), retires at g+2.
    int         cyc = 0;
    int         m_g;
    bit         model_ready, ref_init;
    logic [7:0] ref_mem [32];
    logic       m_act, m_w, m_we, m_last, m_lk, m_lk_on, m_lk_who, r0, r1;
    logic [4:0] m_addr;
    logic [7:0] m_wd, e_rd0, e_rd1;
    logic       e_ack0, e_ack1;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            if (!ref_init) begin
                for (int i = 0; i < 32; i++) ref_mem[i] = 8'(8'h10 + i);
                ref_init = 1'b1;
            end
            m_act = 0; m_last = 1; m_we = 0; m_addr = 0; m_wd = 0; m_w = 0; m_lk = 0;
            e_ack0 = 0; e_ack1 = 0; e_rd0 = 0; e_rd1 = 0;
            m_lk_on = 0; m_lk_who = 0;
            model_ready = 1'b1;
        end else if (m_act) begin
            if (cyc == m_g + 1) begin
                if (m_we) ref_mem[m_addr] = m_wd;
                else if (m_w) e_rd1 = ref_mem[m_addr];
                else e_rd0 = ref_mem[m_addr];
                if (m_w) e_ack1 = 1; else e_ack0 = 1;
            end else begin
                e_ack0 = 0; e_ack1 = 0;
                m_last = m_w;
                m_act = 0;
                if (m_lk) begin
                    m_lk_on = 1; m_lk_who = m_w;
                end else if (m_lk_on && m_lk_who == m_w) begin
                    m_lk_on = 0;
                end
            end
        end else begin
            r0 = req0; r1 = req1;
            if (m_lk_on) begin
                if (m_lk_who) r0 = 0; else r1 = 0;
            end
            if (r0 || r1) begin
                m_w    = (r0 && r1) ? !m_last : r1;
                m_act  = 1;
                m_g    = cyc;
                m_we   = m_w ? we1 : we0;
                m_addr = m_w ? addr1 : addr0;
                m_wd   = m_w ? wdata1 : wdata0;
                m_lk   = m_w ? lock1 : lock0;
            end
        end
    end

    logic exp_we;
    always @(negedge clk) begin
        if (model_ready) begin
            exp_we = m_act && (cyc == m_g) && m_we && rst_n;
            chk("ack0", 32'(ack0), 32'(e_ack0));
            chk("ack1", 32'(ack1), 32'(e_ack1));
            chk("rdata0", 32'(rdata0), 32'(e_rd0));
            chk("rdata1", 32'(rdata1), 32'(e_rd1));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_read_addr", 32'(mem_read_addr), 32'(m_addr));
            chk("mem_write_addr", 32'(mem_write_addr), 32'(m_addr));
            chk("mem_write_data", 32'(mem_write_data), 32'(m_wd));
            if (mem_we) we_cnt++;
            if (ack0) ack0_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic r, input logic w, input logic [4:0] a,
                         input logic [7:0] d, input logic lk);
        if (id == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = lk;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = lk;
        end
    endtask

    task automatic wait_ack(input int id, output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if ((id == 0 && ack0) || (id == 1 && ack1)) begin
                c = cyc;
                break;
            end
        end
        checks++;
        if (c < 0) begin
            errors++;
            $display("FAIL ack%0d_timeout actual=none required=ack within 60 cycles", id);
        end
    endtask

    task automatic access(input int id, input logic w, input logic [4:0] a, input logic [7:0] d,
                          input logic lk, output int c, output logic [7:0] rd);
        drive(id, 1'b1, w, a, d, lk);
        wait_ack(id, c);
        rd = (id == 0) ? rdata0 : rdata1;
        tick();
        drive(id, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    endtask

    int         s, c0, c1, c2, c3;
    int         cs [4];
    logic [7:0] rd0, rd1, rd2, rd3;
    logic [7:0] rds [4];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 5'd0, 8'd0, 0);
        drive(1, 0, 0, 5'd0, 8'd0, 0);
        repeat (3) tick();
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_read_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // write then read back through requester 0
        we_cnt = 0;
        s = cyc;
        access(0, 1'b1, 5'd3, 8'hA5, 1'b0, c0, rd0);
        chk("t1_ack_latency", 32'(c0 - s), 32'd2);
        chk("t1_we_pulses", 32'(we_cnt), 32'd1);
        chk("t1_mem3", 32'(env_mem[3]), 32'hA5);
        chk("t1_ref_mem3", 32'(ref_mem[3]), 32'hA5);
        access(0, 1'b0, 5'd3, 8'h00, 1'b0, c0, rd0);
        chk("t1_read3", 32'(rd0), 32'hA5);

        // tie after requester 0 was served last: requester 1 wins first
        s = cyc;
        fork
            access(0, 1'b0, 5'd10, 8'h00, 1'b0, c0, rd0);
            access(1, 1'b0, 5'd11, 8'h00, 1'b0, c1, rd1);
        join
        chk("t2a_ack1_at", 32'(c1 - s), 32'd2);
        chk("t2a_ack0_at", 32'(c0 - s), 32'd5);
        chk("t2a_rd0", 32'(rd0), 32'h1A);
        chk("t2a_rd1", 32'(rd1), 32'h1B);

        // tie right after reset: requester 0 wins first
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        s = cyc;
        fork
            access(0, 1'b0, 5'd10, 8'h00, 1'b0, c0, rd0);
            access(1, 1'b0, 5'd3, 8'h00, 1'b0, c1, rd1);
        join
        chk("t2b_ack0_at", 32'(c0 - s), 32'd2);
        chk("t2b_ack1_at", 32'(c1 - s), 32'd5);
        chk("t2b_rd1", 32'(rd1), 32'hA5);

        // requester 1 holds req for four back-to-back accesses
        ack0_cnt = 0;
        drive(1, 1, 1, 5'd20, 8'h5A, 0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(1, cs[k]);
            rds[k] = rdata1;
            tick();
            case (k)
                0: drive(1, 1, 0, 5'd20, 8'h00, 0);
                1: drive(1, 1, 1, 5'd21, 8'h3C, 0);
                2: drive(1, 1, 0, 5'd21, 8'h00, 0);
                default: drive(1, 0, 0, 5'd0, 8'h00, 0);
            endcase
        end
        chk("t3_gap01", 32'(cs[1] - cs[0]), 32'd3);
        chk("t3_gap12", 32'(cs[2] - cs[1]), 32'd3);
        chk("t3_gap23", 32'(cs[3] - cs[2]), 32'd3);
        chk("t3_write_keeps_rdata", 32'(rds[0]), 32'hA5);
        chk("t3_rd20", 32'(rds[1]), 32'h5A);
        chk("t3_rd21", 32'(rds[3]), 32'h3C);
        chk("t3_no_ack0", 32'(ack0_cnt), 32'd0);

        // reset lands in the ACCESS cycle of a write
        we_cnt = 0;
        ack0_cnt = 0;
        drive(0, 1, 1, 5'd7, 8'hFF, 0);
        tick();
        rst_n = 1'b0;
        tick();
        drive(0, 0, 0, 5'd0, 8'h00, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t4_mem7", 32'(env_mem[7]), 32'h17);
        chk("t4_ref_mem7", 32'(ref_mem[7]), 32'h17);
        chk("t4_no_write", 32'(we_cnt), 32'd0);
        chk("t4_no_ack", 32'(ack0_cnt), 32'd0);
        chk("t4_rdata1", 32'(rdata1), 32'd0);
        chk("t4_wdata_out", 32'(mem_write_data), 32'd0);
        chk("t4_waddr_out", 32'(mem_write_addr), 32'd0);
        access(1, 1'b0, 5'd7, 8'h00, 1'b0, c1, rd1);
        chk("t4_read7", 32'(rd1), 32'h17);

`ifdef DMEM_ARB_LOCK_EN
        // locked read-modify-write by requester 0 while requester 1 waits
        fork
            begin
                access(0, 1'b0, 5'd5, 8'h00, 1'b1, c0, rd0);
                repeat (3) tick();
                access(0, 1'b1, 5'd5, 8'h11, 1'b0, c2, rd2);
            end
            begin
                tick();
                access(1, 1'b0, 5'd5, 8'h00, 1'b0, c3, rd3);
            end
        join
        chk("t5_first_read", 32'(rd0), 32'h15);
        chk("t5_req1_after_unlock", 32'(c3 > c2), 32'd1);
        chk("t5_req1_reads_new", 32'(rd3), 32'h11);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 32x8 data memory.
- Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader.
- Sits between both requesters and the single memory port: combinational read, write on posedge clk.
- Round-robin grant; each access runs a fixed 3-state sequence; registered ack and read data back to the winner.

Parameters:
ADDR_W, 5, memory address width (32 entries)
DATA_W, 8, memory word width

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
req0 / req1  in  1  access request, held until ack seen
we0 / we1  in  1  1 = write, 0 = read; valid with req
addr0 / addr1  in  ADDR_W  access address
wdata0 / wdata1  in  DATA_W  write data
ack0 / ack1  out  1  one-cycle completion pulse
rdata0 / rdata1  out  DATA_W  read result, valid in ack cycle, held until that requester's next ack
mem_we  out  1  memory write enable
mem_read_addr  out  ADDR_W  memory read address
mem_write_addr  out  ADDR_W  memory write address
mem_write_data  out  DATA_W  memory write data
mem_read_data  in  DATA_W  memory combinational read data

Behaviour:
- Reset (rst_n low at posedge):
  - state = IDLE; ack0/1 = 0; rdata0/1 = 0.
  - Latched addr, we and wdata = 0, so all mem_* outputs = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- IDLE:
  - Sample req0/req1. If none, stay.
  - If exactly one is asserted, grant it.
  - If both are asserted, grant the requester != last_grant.
  - Latch winner id, we, addr and wdata; go to ACCESS.
- ACCESS (one cycle):
  - mem_read_addr = mem_write_addr = latched addr; mem_write_data = latched wdata.
  - mem_we = latched we AND rst_n, so a write is suppressed if reset is asserted in this cycle.
  - At the closing edge: for a read, capture mem_read_data into the winner's rdata; for a write, rdata is unchanged.
  - Set winner's ack; go to DONE.
- DONE (one cycle):
  - Winner's ack = 1 and mem_we = 0.
  - At the closing edge: ack cleared, last_grant = winner, go to IDLE.
  - req is ignored in DONE.
- Latency and throughput:
  - req sampled at edge e0 → ack high during the cycle after e1 → next arbitration at e3.
  - Max throughput is one access per 3 cycles.
- Requester protocol:
  - Keep req, we, addr and wdata stable until ack; drop req on the edge ending the ack cycle.
  - A req still high at the next IDLE sample is treated as a new request.
- mem_* outputs hold the last latched values in IDLE/DONE, with mem_we = 0.
- The loser's req is held pending, not dropped; it is granted at the next IDLE, so there is no starvation.
- Reset mid-ACCESS: no write reaches memory, no ack, no rdata update. Reset mid-DONE: ack is cleared at that edge.
- Simultaneous read and write to the same address from different requesters is serialised; the read returns the value present in its own ACCESS cycle.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN adds inputs lock0 and lock1 (1 bit each), sampled with req at grant.
- If the winner's lock is high, the next IDLE arbitrates only that requester's req; the other req is ignored until a locked-owner access completes with lock low. This gives atomic read-modify-write.
- While locked, IDLE waits indefinitely for the owner.
- Reset clears the lock.
- Without the macro: no lock ports, pure round-robin as above.

Test Plan:
- Reset, then req0 write addr=3 data=8'hA5 → mem_we = 1 for exactly one cycle with write_addr = 3, ack0 2 cycles after the req sample. Then req0 read addr=3 → rdata0 = 8'hA5 in the ack0 cycle.
- req0 and req1 both read on the same cycle after reset → requester 0 served first, requester 1's ack 3 cycles later. Repeat both → order alternates 1 then 0.
- req1 held continuously for 4 accesses with req0 idle → ack1 every 3 cycles, no ack0, mem_we per we1.
- rst_n low during an ACCESS cycle of a write of 8'hFF to addr=7 → addr 7 keeps its old value, no ack, state IDLE, all outputs 0.
- With DMEM_ARB_LOCK_EN: req0 lock=1 read addr=5, req1 pending, then req0 lock=0 write addr=5 = 8'h11 → req1 not granted until after req0's second ack; req1 then reads 8'h11 from addr 5.
